// File: rtl/sound_packetizer_pkg.sv
// Shared definitions for the capture packetizer: FSM encoding, sample layout,
// byte-lane slices (common with the playback buffer) and packet sizing.
package sound_packetizer_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;
    localparam logic [1:0] ST_SEND = 2'd3;

    localparam int LANE_W    = 8;
    localparam int LANE0_LSB = 24;
    localparam int LANE1_LSB = 16;
    localparam int LANE2_LSB = 8;
    localparam int LANE3_LSB = 0;

    typedef struct packed {
        logic [15:0] left;
        logic [15:0] right;
    } sample_t;

    // Lane 0 is the most significant byte: L-hi, L-lo, R-hi, R-lo on the wire.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[LANE0_LSB +: LANE_W];
            2'd1:    return word[LANE1_LSB +: LANE_W];
            2'd2:    return word[LANE2_LSB +: LANE_W];
            default: return word[LANE3_LSB +: LANE_W];
        endcase
    endfunction

    function automatic int packet_bytes(input int samples);
        return 4 * samples;
    endfunction
endpackage

// File: rtl/sound_packetizer_if.sv
// TX-link side of the packetizer: request/grant plus the byte stream handshake.
interface sound_packetizer_if;
    logic       sound_packet_req;
    logic       tx_grant;
    logic       sound_packet;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_last;

    modport master (output sound_packet_req, sound_packet, tx_valid, tx_data, tx_last,
                    input  tx_grant, tx_ready);
    modport slave  (input  sound_packet_req, sound_packet, tx_valid, tx_data, tx_last,
                    output tx_grant, tx_ready);
endinterface

// File: rtl/sound_packetizer_sample_fifo.sv
// Synchronous 32-bit sample FIFO with a registered read port (1-cycle latency).
module sample_fifo #(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    output logic [31:0]   rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_wr, do_rd;

    // Full comes from the registered count, so a same-cycle read cannot admit a write.
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk)
        if (do_wr) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sound_packetizer.sv
// Queues stereo capture samples and streams whole packets as big-endian bytes.
// Define SOUND_TX_OVF_CNT_EN to expose a saturating drop counter on debug.
module sound_packetizer
    import sound_packetizer_pkg::*;
#(
    parameter int PACKET_SAMPLES = 16,
    parameter int FIFO_DEPTH     = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 new_sample,
    input  logic [15:0]          left_in,
    input  logic [15:0]          right_in,
    sound_packetizer_if.master   tx,
    output logic [7:0]           debug
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(PACKET_SAMPLES) + 1;

    logic [1:0]    state;
    logic [1:0]    idx;
    logic [SW-1:0] scnt;
    logic [31:0]   word;
    logic [CW-1:0] count;
    logic          full, empty;
    logic          fifo_rd;
    logic [31:0]   fifo_dout;
    logic          req_q, sp_q, valid_q, last_q;
    logic [7:0]    data_q;
    logic          accept, last_sample;
    sample_t       s_in;

    assign s_in        = '{left: left_in, right: right_in};
    assign accept      = valid_q & tx.tx_ready;
    assign last_sample = (scnt == SW'(PACKET_SAMPLES - 1));

    // Pop on grant, then prefetch the next word while byte 1 goes out.
    assign fifo_rd = ~empty & ((state == ST_REQ  & tx.tx_grant) |
                               (state == ST_SEND & accept & idx == 2'd1 & ~last_sample));

    sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset),
        .wr_en(new_sample), .wr_data(s_in),
        .rd_en(fifo_rd), .rd_data(fifo_dout),
        .count(count), .full(full), .empty(empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            scnt    <= '0;
            word    <= '0;
            req_q   <= 1'b0;
            sp_q    <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            sp_q <= 1'b0;
            case (state)
                ST_IDLE: if (count >= CW'(PACKET_SAMPLES)) begin
                    state <= ST_REQ;
                    req_q <= 1'b1;
                end
                ST_REQ: if (tx.tx_grant) begin
                    state <= ST_LOAD;
                    req_q <= 1'b0;
                end
                ST_LOAD: begin
                    word    <= fifo_dout;
                    data_q  <= byte_lane(fifo_dout, 2'd0);
                    valid_q <= 1'b1;
                    last_q  <= 1'b0;
                    sp_q    <= 1'b1;
                    idx     <= '0;
                    scnt    <= '0;
                    state   <= ST_SEND;
                end
                default: if (accept) begin
                    if (idx != 2'd3) begin
                        idx    <= idx + 2'd1;
                        data_q <= byte_lane(word, idx + 2'd1);
                        last_q <= (idx == 2'd2) & last_sample;
                    end else if (last_sample) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        word   <= fifo_dout;
                        data_q <= byte_lane(fifo_dout, 2'd0);
                        idx    <= '0;
                        scnt   <= scnt + SW'(1);
                    end
                end
            endcase
        end
    end

    assign tx.sound_packet_req = req_q;
    assign tx.sound_packet     = sp_q;
    assign tx.tx_valid         = valid_q;
    assign tx.tx_data          = data_q;
    assign tx.tx_last          = last_q;

`ifdef SOUND_TX_OVF_CNT_EN
    logic [7:0] drops;
    always_ff @(posedge clk) begin
        if (reset)                                    drops <= '0;
        else if (new_sample & full & drops != 8'hFF)  drops <= drops + 8'd1;
    end
    assign debug = drops;
`else
    logic [3:0] cnt4;
    if (CW >= 4) begin : g_cnt_trunc
        assign cnt4 = count[3:0];
    end else begin : g_cnt_ext
        assign cnt4 = 4'(count);
    end
    assign debug = {state, 1'b0, full, cnt4};
`endif
endmodule

// File: tb/tb_sound_packetizer.sv
// Directed-plus-random bench: a queue model of the sample FIFO predicts packet bytes.
module tb_sound_packetizer;
    localparam int PS = 2;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_sample = 1'b0;
    logic [15:0] left_in = '0, right_in = '0;
    logic [7:0]  debug;
    int          checks = 0, failures = 0;
    logic [31:0] model_q[$];
    int          model_drops = 0;

    sound_packetizer_if tx_if();

    sound_packetizer #(.PACKET_SAMPLES(PS), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .new_sample(new_sample),
        .left_in(left_in), .right_in(right_in), .tx(tx_if), .debug(debug)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        new_sample = 1'b1;
        left_in    = w[31:16];
        right_in   = w[15:0];
        if (model_q.size() < FD) model_q.push_back(w);
        else                     model_drops++;
        tick;
        new_sample = 1'b0;
    endtask

    task automatic wait_req;
        int n = 0;
        while (!tx_if.sound_packet_req && n < 20) begin
            tick;
            n++;
        end
        chk("req_wait", tx_if.sound_packet_req, 1'b1);
    endtask

    // Grant one packet and collect it; optionally strobe a sample or reset at a byte index.
    task automatic run_packet(input bit toggle, input int strobe_at, input int reset_at);
        logic [7:0]  exp_b[$];
        logic [7:0]  got[$];
        logic [31:0] w;
        logic [7:0]  hd;
        logic        hl;
        logic [3:0]  cnt_before;
        int          nlast = 0, nsp = 0, nvalid = 0;
        bit          held = 0, done = 0, strobed = 0, strobe_now;
        for (int s = 0; s < PS; s++) begin
            w = model_q.pop_front();
            for (int k = 0; k < 4; k++) exp_b.push_back(w[31 - 8*k -: 8]);
        end
        tx_if.tx_ready = 1'b0;
        tx_if.tx_grant = 1'b1;
        tick;
        tx_if.tx_grant = 1'b0;
        chk("grant_t1_valid", tx_if.tx_valid, 1'b0);
        chk("grant_t1_sp", tx_if.sound_packet, 1'b0);
        tick;
        chk("grant_t2_sp", tx_if.sound_packet, 1'b1);
        chk("grant_t2_valid", tx_if.tx_valid, 1'b1);
        for (int c = 0; c < 400 && !done; c++) begin
            tx_if.tx_ready = toggle ? (c % 2 == 0) : 1'b1;
            strobe_now = 0;
            if (held) begin
                chk("stall_data", tx_if.tx_data, hd);
                chk("stall_valid", tx_if.tx_valid, 1'b1);
                chk("stall_last", tx_if.tx_last, hl);
            end
            nsp += int'(tx_if.sound_packet);
            if (tx_if.tx_valid) nvalid++;
            if (tx_if.tx_valid && got.size() == reset_at) begin
                reset = 1'b1;
                tick;
                reset = 1'b0;
                chk("rst_valid", tx_if.tx_valid, 1'b0);
                chk("rst_req", tx_if.sound_packet_req, 1'b0);
`ifndef SOUND_TX_OVF_CNT_EN
                chk("rst_count", debug[3:0], 4'd0);
`endif
                model_q.delete();
                return;
            end
            if (tx_if.tx_valid && tx_if.tx_ready && got.size() == strobe_at && !strobed) begin
                w = $urandom;
                new_sample = 1'b1;
                left_in    = w[31:16];
                right_in   = w[15:0];
                model_q.push_back(w);
                cnt_before = debug[3:0];
                strobed    = 1;
                strobe_now = 1;
            end
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                got.push_back(tx_if.tx_data);
                if (tx_if.tx_last) begin
                    nlast++;
                    done = 1;
                end
                held = 0;
            end else if (tx_if.tx_valid) begin
                held = 1;
                hd   = tx_if.tx_data;
                hl   = tx_if.tx_last;
            end
            tick;
            if (strobe_now) begin
                new_sample = 1'b0;
`ifndef SOUND_TX_OVF_CNT_EN
                chk("simul_count", debug[3:0], cnt_before);
`endif
            end
        end
        chk("pkt_done", done, 1'b1);
        chk("pkt_len", got.size(), 4 * PS);
        chk("pkt_last_cnt", nlast, 1);
        chk("pkt_sp_cnt", nsp, 1);
        if (!toggle) chk("throughput", nvalid, 4 * PS);
        for (int i = 0; i < exp_b.size(); i++)
            chk($sformatf("byte%0d", i), (i < got.size()) ? {24'd0, got[i]} : 32'hxxxxxxxx,
                {24'd0, exp_b[i]});
        chk("idle_after", tx_if.tx_valid, 1'b0);
    endtask

    initial begin
        tx_if.tx_grant = 1'b0;
        tx_if.tx_ready = 1'b0;
        tick;
        tick;
        chk("rst_req0", tx_if.sound_packet_req, 1'b0);
        chk("rst_sp0", tx_if.sound_packet, 1'b0);
        chk("rst_valid0", tx_if.tx_valid, 1'b0);
        chk("rst_last0", tx_if.tx_last, 1'b0);
        chk("rst_data0", tx_if.tx_data, 8'h00);
        chk("rst_debug0", debug, 8'h00);
        reset = 1'b0;
        tick;

        // Grant while idle must be ignored.
        tx_if.tx_grant = 1'b1;
        tick;
        tx_if.tx_grant = 1'b0;
        tick;
        tick;
        chk("stray_grant_valid", tx_if.tx_valid, 1'b0);
        chk("stray_grant_sp", tx_if.sound_packet, 1'b0);

        // Basic packet, with request latency.
        push(32'h1234_ABCD);
        push(32'h0001_FFFF);
        chk("req_not_yet", tx_if.sound_packet_req, 1'b0);
        tick;
        chk("req_rise", tx_if.sound_packet_req, 1'b1);
        run_packet(1'b0, -1, -1);

        // Backpressure.
        push($urandom);
        push($urandom);
        wait_req;
        run_packet(1'b1, -1, -1);

        // Overflow: six strobes into a four-deep FIFO.
        for (int i = 0; i < 6; i++) push($urandom);
        tick;
        chk("ovf_model_drops", model_drops, 2);
`ifdef SOUND_TX_OVF_CNT_EN
        chk("ovf_debug_drops", debug, 8'd2);
`else
        chk("ovf_count", debug[3:0], 4'd4);
        chk("ovf_full", debug[4], 1'b1);
`endif
        wait_req;
        run_packet(1'b0, -1, -1);
        wait_req;
        run_packet(1'b0, -1, -1);

        // Write coinciding with the prefetch pop of byte 1.
        push($urandom);
        push($urandom);
        wait_req;
        run_packet(1'b0, 1, -1);
`ifndef SOUND_TX_OVF_CNT_EN
        chk("simul_left", debug[3:0], 4'd1);
`endif
        push($urandom);
        wait_req;
        run_packet(1'b0, -1, -1);

        // Reset mid-packet, then a clean packet of fresh samples.
        push($urandom);
        push($urandom);
        wait_req;
        run_packet(1'b0, -1, 5);
        tick;
        chk("post_rst_valid", tx_if.tx_valid, 1'b0);
        push($urandom);
        push($urandom);
        wait_req;
        run_packet(1'b0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
